// File: rtl/sprite_pkg.sv
// Shared sizing constants and types for the sprite ROM read path.
package sprite_pkg;

  localparam int unsigned SPRITE_ROM_ADDR_W = 8;
  localparam int unsigned SPRITE_ROM_DATA_W = 3;
  localparam int unsigned NUM_SPRITE_REQ    = 4;

  typedef logic [SPRITE_ROM_ADDR_W-1:0] rom_addr_t;
  typedef logic [SPRITE_ROM_DATA_W-1:0] rom_data_t;
  typedef logic [NUM_SPRITE_REQ-1:0]    req_vec_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request after ptr, modulo N, as one-hot plus index.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int unsigned    pos;

  always_comb begin
    req_dbl = {req, req};
    // bit k of req_rot is requester (ptr+1+k) mod N; ptr=N-1 shifts by N, i.e. starts at 0
    req_rot = N'(req_dbl >> (32'(ptr) + 32'd1));
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pos   = 32'(ptr) + k + 1;
        if (pos >= N) pos = pos - N;
      end
    end
    if (found) begin
      gnt = N'(1) << pos;
      idx = IDX_W'(pos);
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM port among NUM_REQ renderers; responses
// return ROM_LAT+1 cycles after the grant, tagged with a one-hot valid.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_SPRITE_REQ,
  parameter int unsigned ADDR_W     = SPRITE_ROM_ADDR_W,
  parameter int unsigned DATA_W     = SPRITE_ROM_DATA_W,
  parameter int unsigned ROM_LAT    = 1,
  parameter bit          FIXED_PRI0 = 1'b1
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  typedef struct packed {
    logic               valid;
    logic [NUM_REQ-1:0] tag;
  } tag_t;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   rr_idx, gnt_idx;
  logic [NUM_REQ-1:0] rr_gnt;
  logic               rr_found, pri0_win, any_gnt;
  logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
  tag_t               tag_q [ROM_LAT];
  tag_t               tag_d [ROM_LAT];
  tag_t               tag_last;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_comb begin
    pri0_win = FIXED_PRI0 && req[0];
    gnt      = '0;
    gnt_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    if (!reset) begin
      if (pri0_win) begin
        gnt = NUM_REQ'(1);
      end else if (rr_found) begin
        gnt      = rr_gnt;
        gnt_idx  = rr_idx;
        rr_ptr_d = rr_idx;
      end
    end
    any_gnt       = |gnt;
    rom_address_d = any_gnt ? req_addr[gnt_idx*ADDR_W +: ADDR_W] : rom_address_q;

    tag_d[0] = '{valid: any_gnt, tag: gnt};
    for (int unsigned k = 1; k < ROM_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    tag_last = tag_q[ROM_LAT-1];
    if (tag_last.valid) begin
      rsp_valid_d = tag_last.tag;
      rsp_data_d  = rom_q;
    end else begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q      <= PTR_RST;
      rom_address_q <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      for (int unsigned k = 0; k < ROM_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rom_address_q <= rom_address_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      for (int unsigned k = 0; k < ROM_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign rom_address = rom_address_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule
